// File: rtl/enc_stage3.sv
// Third encryption round: nibble S-box, key-mask XOR and round-state permutation,
// buffered in a small output FIFO with valid/ready handshakes on both sides.
//
//  state | meaning
//  R0    | no permutation
//  R1    | rotate left 4
//  R2    | rotate right 4
//  R3    | byte swap
module enc_stage3 #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [15:0]      in_data,
   input  logic [3:0]       key_nib,
   input  logic [1:0]       key_bits,
   output logic             ready_out,
   output logic [15:0]      out_data,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [1:0] R0 = 2'd0;
   localparam logic [1:0] R1 = 2'd1;
   localparam logic [1:0] R2 = 2'd2;
   localparam logic [1:0] R3 = 2'd3;

   logic [15:0]      mem_q [DEPTH];
   logic [15:0]      mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [1:0]       st_q, st_d;
   logic [CNT_W-1:0] wc_q, wc_d;

   logic        push, pop;
   logic [15:0] s, x, xf;

   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] r;
      case (n)
         4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
         4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
         4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
         4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
      endcase
      return r;
   endfunction

   assign ready_out = (cnt_q != FULL_CNT);
   assign valid_out = (cnt_q != '0);
   assign out_data  = valid_out ? mem_q[rd_q] : 16'h0000;
   assign word_cnt  = wc_q;

   always_comb begin
      s = {sbox(in_data[15:12]), sbox(in_data[11:8]), sbox(in_data[7:4]), sbox(in_data[3:0])};
      x = s ^ {key_nib, ~key_nib, key_nib, ~key_nib};
      case (st_q)
         R0:      xf = x;
         R1:      xf = {x[11:0], x[15:12]};
         R2:      xf = {x[3:0], x[15:4]};
         default: xf = {x[7:0], x[15:8]};
      endcase
   end

   always_comb begin
      push  = valid_in && ready_out;
      pop   = valid_out && ready_in;
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      st_d  = st_q;
      wc_d  = wc_q;
      if (push) begin
         mem_d[wr_q] = xf;
         wr_d        = wr_q + 1'b1;
         st_d        = st_q + key_bits + 2'd1;
         wc_d        = wc_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      // push is blocked when full, so push&pop only happens with room to spare
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         st_q  <= R0;
         wc_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         st_q  <= st_d;
         wc_q  <= wc_d;
      end
   end

endmodule

// File: tb/tb_enc_stage3.sv
// Scoreboard bench for enc_stage3: a reference model queues expected words on
// accept and a monitor compares them as the DUT hands them downstream.
module tb_enc_stage3;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [15:0] in_data;
   logic [3:0]  key_nib;
   logic [1:0]  key_bits;
   logic        ready_out;
   logic [15:0] out_data;
   logic        valid_out;
   logic        ready_in;
   logic [7:0]  word_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [15:0] exp_q [$];
   logic [1:0]  m_state;
   logic [7:0]  m_cnt;

   enc_stage3 #(.DEPTH(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .in_data(in_data),
      .key_nib(key_nib), .key_bits(key_bits), .ready_out(ready_out),
      .out_data(out_data), .valid_out(valid_out), .ready_in(ready_in),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_sbox(input logic [3:0] n);
      logic [63:0] tbl;
      tbl = 64'hC56B90AD3EF84712;
      return tbl[60 - 4*n +: 4];
   endfunction

   function automatic logic [15:0] ref_xf(input logic [15:0] d, input logic [3:0] k,
                                          input logic [1:0] st);
      logic [15:0] v;
      for (int i = 0; i < 4; i++) v[4*i +: 4] = ref_sbox(d[4*i +: 4]);
      v = v ^ {k, ~k, k, ~k};
      if (st == 2'd1)      v = {v[11:0], v[15:12]};
      else if (st == 2'd2) v = {v[3:0], v[15:4]};
      else if (st == 2'd3) v = {v[7:0], v[15:8]};
      return v;
   endfunction

   // Inputs change #1 after posedge; acceptance is judged from ready_out at negedge.
   task automatic send(input logic [15:0] d, input logic [3:0] k, input logic [1:0] kb);
      logic acc;
      int   n;
      valid_in = 1'b1;
      in_data  = d;
      key_nib  = k;
      key_bits = kb;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = ready_out;
         @(posedge clk);
         #1;
         n++;
      end
      if (acc) begin
         exp_q.push_back(ref_xf(d, k, m_state));
         m_state = m_state + kb + 2'd1;
         m_cnt   = m_cnt + 8'd1;
      end else begin
         chk("send_timeout", 32'd0, 32'd1);
      end
      valid_in = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && valid_out && ready_in) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", {16'h0, out_data}, 32'hDEAD);
         end else begin
            chk("scoreboard", {16'h0, out_data}, {16'h0, exp_q[0]});
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int t0;
      rst = 1'b1; valid_in = 1'b0; in_data = '0; key_nib = '0; key_bits = '0; ready_in = 1'b0;
      m_state = 2'd0; m_cnt = 8'd0;
      #23;
      chk("rst_valid", valid_out, 0);
      chk("rst_data", out_data, 0);
      chk("rst_cnt", word_cnt, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", ready_out, 1);

      // round-state walk with all-zero words
      ready_in = 1'b1;
      send(16'h0000, 4'h0, 2'b00);
      chk("w1_valid", valid_out, 1);
      chk("w1_r0", out_data, 32'hC3C3);
      chk("w1_cnt", word_cnt, 1);
      send(16'h0000, 4'h0, 2'b00);
      chk("w2_r1", out_data, 32'h3C3C);
      send(16'h0000, 4'h0, 2'b00);
      chk("w3_r2", out_data, 32'h3C3C);
      send(16'h0000, 4'h0, 2'b00);
      chk("w4_r3", out_data, 32'hC3C3);
      send(16'h0000, 4'h0, 2'b01);
      chk("w5_r0", out_data, 32'hC3C3);
      send(16'h1234, 4'hA, 2'b00);
      chk("w6_r2", out_data, 32'hCF31);
      chk("w6_cnt", word_cnt, 6);
      drain();

      // backpressure: FIFO fills after two accepts, third word is held
      ready_in = 1'b0;
      send(16'hBEEF, 4'h3, 2'b10);
      send(16'h0F0F, 4'h7, 2'b11);
      chk("full_ready", ready_out, 0);
      valid_in = 1'b1; in_data = 16'hA55A; key_nib = 4'h5; key_bits = 2'b01;
      repeat (3) @(posedge clk);
      #1;
      chk("held_cnt", word_cnt, {24'h0, m_cnt});
      chk("held_valid", valid_out, 1);
      chk("held_head", out_data, {16'h0, exp_q[0]});
      ready_in = 1'b1;
      @(negedge clk);
      chk("pop_cycle_ready", ready_out, 0);
      @(posedge clk); #1;
      chk("after_pop_ready", ready_out, 1);
      send(16'hA55A, 4'h5, 2'b01);
      drain();

      // streaming: one word per cycle, counter wraps
      t0 = cyc;
      for (int i = 0; i < 300; i++)
         send(16'($urandom), 4'($urandom), 2'($urandom));
      chk("stream_cycles", cyc - t0, 300);
      chk("stream_cnt", word_cnt, {24'h0, m_cnt});
      drain();

      // reset with two words buffered
      ready_in = 1'b0;
      send(16'h1111, 4'h1, 2'b00);
      send(16'h2222, 4'h2, 2'b00);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_cnt", word_cnt, 0);
      exp_q.delete();
      m_state = 2'd0; m_cnt = 8'd0;
      #10;
      rst = 1'b0;
      ready_in = 1'b1;
      @(posedge clk); #1;
      send(16'h0000, 4'h0, 2'b00);
      chk("post_rst_r0", out_data, 32'hC3C3);
      chk("post_rst_cnt", word_cnt, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
